// File: rtl/osd_trace_pkg.sv
// Shared definitions for the trace event stamper: flit width, packet type codes,
// output FSM state encoding and a TYPE-flit builder.
package osd_trace_pkg;

  localparam int FLIT_W = 16;

  localparam logic [1:0] TYPE_EVENT    = 2'b01;
  localparam logic [1:0] TYPE_OVERFLOW = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    TYPE,
    TSTAMP,
    PAYLOAD
  } stamper_state_t;

  function automatic logic [FLIT_W-1:0] type_flit(input logic [1:0] code);
    return {code, {(FLIT_W-2){1'b0}}};
  endfunction

endpackage

// File: rtl/osd_stamper_fifo.sv
// Small event buffer with combinational read of the head entry so the packet
// engine can load it in the same cycle it pops.
module osd_stamper_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers are AW bits wide and DEPTH is a power of two, so they wrap for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/osd_event_stamper.sv
// Timestamps trace events, buffers them and emits 3-flit debug packets.
// Define OSD_EVENT_STAMPER_OVERFLOW_EN to count drops and report them as overflow packets.
module osd_event_stamper
  import osd_trace_pkg::*;
#(
  parameter int TS_WIDTH   = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [TS_WIDTH-1:0]   timestamp,
  input  logic                  event_valid,
  input  logic [DATA_WIDTH-1:0] event_data,
  output logic [FLIT_W-1:0]     out_flit,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int ENTRY_W = TS_WIDTH + DATA_WIDTH;

  logic               capture;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_din;
  logic [ENTRY_W-1:0] fifo_dout;
  logic               in_idle;
  logic               ovf_pending;

  stamper_state_t     state_reg;
  logic [FLIT_W-1:0]  flit_reg;
  logic [FLIT_W-1:0]  ts_flit_reg;
  logic [FLIT_W-1:0]  payload_flit_reg;
  logic               last_reg;
  logic               valid_reg;

  assign capture   = event_valid & enable;
  assign fifo_push = capture & ~fifo_full;
  assign fifo_din  = {timestamp, event_data};
  assign in_idle   = (state_reg == IDLE);
  // A pending overflow report wins over the FIFO, so no pop in that cycle.
  assign fifo_pop  = in_idle & ~ovf_pending & ~fifo_empty;

  osd_stamper_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .din   (fifo_din),
    .dout  (fifo_dout)
  );

`ifdef OSD_EVENT_STAMPER_OVERFLOW_EN
  logic                drop;
  logic                ovf_load;
  logic [15:0]         drop_cnt_reg;
  logic [TS_WIDTH-1:0] drop_ts_reg;

  assign drop     = capture & fifo_full;
  assign ovf_load = in_idle & ovf_pending;

  // The timestamp of the first drop in a run is kept; later drops only count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_reg <= '0;
      drop_ts_reg  <= '0;
    end else if (ovf_load) begin
      drop_cnt_reg <= drop ? 16'd1 : 16'd0;
      if (drop) begin
        drop_ts_reg <= timestamp;
      end
    end else if (drop) begin
      if (drop_cnt_reg == '0) begin
        drop_ts_reg <= timestamp;
      end
      if (drop_cnt_reg != '1) begin
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
    end
  end

  assign ovf_pending = (drop_cnt_reg != '0);
`else
  assign ovf_pending = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      flit_reg         <= '0;
      ts_flit_reg      <= '0;
      payload_flit_reg <= '0;
      last_reg         <= 1'b0;
      valid_reg        <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: begin
`ifdef OSD_EVENT_STAMPER_OVERFLOW_EN
          if (ovf_pending) begin
            flit_reg         <= type_flit(TYPE_OVERFLOW);
            ts_flit_reg      <= FLIT_W'(drop_ts_reg);
            payload_flit_reg <= drop_cnt_reg;
            valid_reg        <= 1'b1;
            state_reg        <= TYPE;
          end else
`endif
          if (!fifo_empty) begin
            flit_reg         <= type_flit(TYPE_EVENT);
            ts_flit_reg      <= FLIT_W'(fifo_dout[ENTRY_W-1 -: TS_WIDTH]);
            payload_flit_reg <= FLIT_W'(fifo_dout[DATA_WIDTH-1:0]);
            valid_reg        <= 1'b1;
            state_reg        <= TYPE;
          end
        end
        TYPE: begin
          if (out_ready) begin
            flit_reg  <= ts_flit_reg;
            state_reg <= TSTAMP;
          end
        end
        TSTAMP: begin
          if (out_ready) begin
            flit_reg  <= payload_flit_reg;
            last_reg  <= 1'b1;
            state_reg <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (out_ready) begin
            flit_reg  <= '0;
            last_reg  <= 1'b0;
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out_flit  = flit_reg;
  assign out_last  = last_reg;
  assign out_valid = valid_reg;

endmodule

// File: tb/tb_osd_event_stamper.sv
// Self-checking bench for osd_event_stamper: directed vector table, corner-case
// sequences and randomized traffic against a queue-based packet model.
module tb_osd_event_stamper;

  localparam int DEPTH = 4;
`ifdef OSD_EVENT_STAMPER_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        event_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] timestamp = '0;
  logic [15:0] event_data = '0;
  logic [15:0] out_flit;
  logic        out_last;
  logic        out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  osd_event_stamper #(
    .TS_WIDTH   (16),
    .DATA_WIDTH (16),
    .DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .timestamp   (timestamp),
    .event_valid (event_valid),
    .event_data  (event_data),
    .out_flit    (out_flit),
    .out_last    (out_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  typedef struct {
    logic        en;
    logic        ev;
    logic [15:0] ts;
    logic [15:0] d;
    logic        rdy;
    logic        exp_v;
    logic [15:0] exp_f;
    logic        exp_l;
  } vec_t;

  vec_t tbl[$];

  // Reference model: packets are lists of flits still to be sent, the buffer
  // is a list of captured {ts,data} pairs, drops are a plain counter.
  logic [15:0] m_cur[$];
  logic [31:0] m_fifo[$];
  int          m_cnt;
  logic [15:0] m_ovf_ts;
  bit          m_loaded_ovf;

  logic [15:0] seen[$];
  bit          collect = 1'b0;

  function automatic vec_t mk(input logic en, input logic ev, input logic [15:0] ts,
                              input logic [15:0] d, input logic rdy, input logic v,
                              input logic [15:0] f, input logic l);
    vec_t r;
    r.en = en; r.ev = ev; r.ts = ts; r.d = d; r.rdy = rdy;
    r.exp_v = v; r.exp_f = f; r.exp_l = l;
    return r;
  endfunction

  task automatic model_clear();
    m_cur.delete();
    m_fifo.delete();
    m_cnt = 0;
    m_ovf_ts = '0;
    m_loaded_ovf = 1'b0;
  endtask

  task automatic model_step(input logic en_i, input logic ev_i, input logic [15:0] ts_i,
                            input logic [15:0] d_i, input logic rdy_i);
    bit          full_now;
    bit          dropped;
    bit          pushed;
    logic [31:0] pkt;
    full_now = (m_fifo.size() == DEPTH);
    dropped  = ev_i && en_i && full_now;
    pushed   = ev_i && en_i && !full_now;
    m_loaded_ovf = 1'b0;
    if (m_cur.size() == 0) begin
      if (OVF_EN && m_cnt != 0) begin
        m_cur = '{16'h8000, m_ovf_ts, m_cnt[15:0]};
        m_loaded_ovf = 1'b1;
      end else if (m_fifo.size() != 0) begin
        pkt = m_fifo.pop_front();
        m_cur = '{16'h4000, pkt[31:16], pkt[15:0]};
      end
    end else if (rdy_i) begin
      void'(m_cur.pop_front());
    end
    if (pushed) m_fifo.push_back({ts_i, d_i});
    if (OVF_EN) begin
      if (m_loaded_ovf) begin
        m_cnt = dropped ? 1 : 0;
        if (dropped) m_ovf_ts = ts_i;
      end else if (dropped) begin
        if (m_cnt == 0) m_ovf_ts = ts_i;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  endtask

  task automatic check(input string name, input logic v, input logic [15:0] f, input logic l);
    n_tests++;
    if (out_valid !== v || out_flit !== f || out_last !== l) begin
      n_fail++;
      $display("FAIL %s @%0t: got valid=%0b flit=%h last=%0b, want valid=%0b flit=%h last=%0b",
               name, $time, out_valid, out_flit, out_last, v, f, l);
    end
  endtask

  task automatic check_model(input string name);
    logic        v;
    logic [15:0] f;
    v = (m_cur.size() != 0);
    f = v ? m_cur[0] : 16'h0000;
    check(name, v, f, m_cur.size() == 1);
  endtask

  task automatic drive(input logic en_i, input logic ev_i, input logic [15:0] ts_i,
                       input logic [15:0] d_i, input logic rdy_i);
    enable = en_i; event_valid = ev_i; timestamp = ts_i; event_data = d_i; out_ready = rdy_i;
  endtask

  // One clock with model update and comparison; called at a negedge.
  task automatic step(input logic en_i, input logic ev_i, input logic [15:0] ts_i,
                      input logic [15:0] d_i, input logic rdy_i);
    drive(en_i, ev_i, ts_i, d_i, rdy_i);
    if (out_valid && rdy_i) begin
      if (collect) seen.push_back(out_flit);
      if (out_last) $display("[TB] packet accepted @%0t, last flit %h", $time, out_flit);
    end
    model_step(en_i, ev_i, ts_i, d_i, rdy_i);
    @(posedge clk);
    @(negedge clk);
    check_model("model");
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_state", 1'b0, 16'h0000, 1'b0);
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    logic [15:0] exp_q[$];
    logic [15:0] got;

    tbl.push_back(mk(1, 1, 16'h0012, 16'hBEEF, 1, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 16'h0013, 16'h0000, 1, 1, 16'h4000, 0));
    tbl.push_back(mk(1, 0, 16'h0014, 16'h0000, 1, 1, 16'h0012, 0));
    tbl.push_back(mk(1, 0, 16'h0015, 16'h0000, 0, 1, 16'h0012, 0));
    tbl.push_back(mk(1, 1, 16'h0034, 16'h0001, 0, 1, 16'h0012, 0));
    tbl.push_back(mk(1, 0, 16'h0017, 16'h0000, 0, 1, 16'h0012, 0));
    tbl.push_back(mk(1, 0, 16'h0018, 16'h0000, 0, 1, 16'h0012, 0));
    tbl.push_back(mk(1, 0, 16'h0019, 16'h0000, 0, 1, 16'h0012, 0));
    tbl.push_back(mk(1, 0, 16'h001A, 16'h0000, 1, 1, 16'hBEEF, 1));
    tbl.push_back(mk(1, 0, 16'h001B, 16'h0000, 1, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 16'h001C, 16'h0000, 1, 1, 16'h4000, 0));
    tbl.push_back(mk(1, 0, 16'h001D, 16'h0000, 1, 1, 16'h0034, 0));
    tbl.push_back(mk(1, 0, 16'h001E, 16'h0000, 1, 1, 16'h0001, 1));
    tbl.push_back(mk(1, 0, 16'h001F, 16'h0000, 1, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 1, 16'h0055, 16'h0055, 1, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 16'h0056, 16'h0000, 1, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 0, 16'h0057, 16'h0000, 1, 0, 16'h0000, 0));

    // Directed table: single event, TSTAMP stall, enable=0 event.
    @(negedge clk);
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].en, tbl[i].ev, tbl[i].ts, tbl[i].d, tbl[i].rdy);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), tbl[i].exp_v, tbl[i].exp_f, tbl[i].exp_l);
    end

    // Burst of 6 events behind a stalled packet: 4 buffered, 2 dropped.
    do_reset();
    step(1, 1, 16'h0100, 16'h00AA, 0);
    for (int k = 1; k <= 6; k++) step(1, 1, 16'h0100 + 16'(k), 16'h00B0 + 16'(k), 0);
    seen.delete();
    collect = 1'b1;
    for (int k = 0; k < 30; k++) step(1, 0, 16'h0200, 16'h0000, 1);
    collect = 1'b0;
    exp_q = '{16'h4000, 16'h0100, 16'h00AA};
    if (OVF_EN) begin
      exp_q.push_back(16'h8000); exp_q.push_back(16'h0105); exp_q.push_back(16'h0002);
    end
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(16'h4000);
      exp_q.push_back(16'h0100 + 16'(k));
      exp_q.push_back(16'h00B0 + 16'(k));
    end
    n_tests++;
    if (seen.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL burst_len: got %0d flits, want %0d", seen.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < seen.size()) ? seen[i] : 16'hxxxx;
      n_tests++;
      if (got !== exp_q[i]) begin
        n_fail++;
        $display("FAIL burst_flit%0d: got %h, want %h", i, got, exp_q[i]);
      end
    end

    // Reset in the middle of PAYLOAD with two events still queued.
    do_reset();
    step(1, 1, 16'h0200, 16'h00C0, 1);
    step(1, 1, 16'h0201, 16'h00C1, 1);
    step(1, 1, 16'h0202, 16'h00C2, 1);
    step(1, 0, 16'h0203, 16'h0000, 1);
    check("pre_reset_payload", 1'b1, 16'h00C0, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("reset_async", 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    for (int k = 0; k < 6; k++) begin
      step(1, 0, 16'h0210, 16'h0000, 1);
      check("post_reset_quiet", 1'b0, 16'h0000, 1'b0);
    end
    step(1, 1, 16'h0220, 16'h00C9, 1);
    step(1, 0, 16'h0221, 16'h0000, 1);
    check("post_reset_new", 1'b1, 16'h4000, 1'b0);
    for (int k = 0; k < 4; k++) step(1, 0, 16'h0222, 16'h0000, 1);

    // Drop in the same cycle the overflow packet loads.
    do_reset();
    step(1, 1, 16'h0300, 16'h00D0, 0);
    for (int k = 1; k <= 6; k++) step(1, 1, 16'h0300 + 16'(k), 16'h00D0 + 16'(k), 0);
    for (int k = 0; k < 20; k++) begin
      step(1, 1, 16'h0310 + 16'(k), 16'h00E0, 1);
      if (m_loaded_ovf) break;
    end
    for (int k = 0; k < 30; k++) step(1, 0, 16'h0330, 16'h0000, 1);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, 16'($urandom),
           16'($urandom), $urandom_range(0, 4) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
